// File: rtl/matvec_sequencer.sv
// matvec_sequencer: drives one external combinational dot-product engine
// to compute y = M*x one row at a time. Latches x at start, fetches each
// row over a req/valid handshake, captures the engine result and emits it
// on a valid/ready stream tagged with its row index.
module matvec_sequencer #(
    parameter  int WIDTH = 32,
    parameter  int LEN   = 8,
    parameter  int ROWS  = 8,
    localparam int IW    = (ROWS > 1) ? $clog2(ROWS) : 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic                      abort,
    input  logic [LEN-1:0][WIDTH-1:0] vec_in,
    output logic                      busy,
    output logic                      done,
    output logic                      row_req,
    output logic [IW-1:0]             row_idx,
    input  logic                      row_valid,
    input  logic [LEN-1:0][WIDTH-1:0] row_data,
    output logic [LEN-1:0][WIDTH-1:0] dot_a,
    output logic [LEN-1:0][WIDTH-1:0] dot_b,
    input  logic [WIDTH-1:0]          dot_result,
    output logic                      res_valid,
    input  logic                      res_ready,
    output logic [WIDTH-1:0]          res_data,
    output logic [IW-1:0]             res_idx
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_FETCH   = 3'd1;
    localparam logic [2:0] S_COMPUTE = 3'd2;
    localparam logic [2:0] S_OUTPUT  = 3'd3;
    localparam logic [2:0] S_DONE    = 3'd4;

    localparam logic [IW-1:0] LAST_ROW = IW'(ROWS - 1);

    logic [2:0]                r_state;
    logic [2:0]                w_state_nxt;
    logic [IW-1:0]             r_row_cnt;
    logic [LEN-1:0][WIDTH-1:0] r_vec;
    logic [LEN-1:0][WIDTH-1:0] r_row;
    logic [WIDTH-1:0]          r_res;

    logic w_accept_start;
    logic w_accept_row;
    logic w_capture_res;
    logic w_accept_res;
    logic w_last_row;

    assign w_last_row     = (r_row_cnt == LAST_ROW);
    assign w_accept_start = (r_state == S_IDLE) && start;
    // abort outranks both handshakes, so it gates every datapath update
    assign w_accept_row   = (r_state == S_FETCH) && !abort && row_valid;
    assign w_capture_res  = (r_state == S_COMPUTE) && !abort;
    assign w_accept_res   = (r_state == S_OUTPUT) && !abort && res_ready;

    // Next-state selection
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) w_state_nxt = S_FETCH;
            end
            S_FETCH: begin
                if (abort)          w_state_nxt = S_IDLE;
                else if (row_valid) w_state_nxt = S_COMPUTE;
            end
            S_COMPUTE: begin
                w_state_nxt = abort ? S_IDLE : S_OUTPUT;
            end
            S_OUTPUT: begin
                if (abort)          w_state_nxt = S_IDLE;
                else if (res_ready) w_state_nxt = w_last_row ? S_DONE : S_FETCH;
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    // Vector latch, row counter, row and result capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vec     <= '0;
            r_row     <= '0;
            r_res     <= '0;
            r_row_cnt <= '0;
        end else begin
            if (w_accept_start) begin
                r_vec     <= vec_in;
                r_row_cnt <= '0;
            end
            if (w_accept_row)  r_row <= row_data;
            if (w_capture_res) r_res <= dot_result;
            if (w_accept_res && !w_last_row) r_row_cnt <= r_row_cnt + IW'(1);
        end
    end

    // Outputs decoded purely from registered state
    always_comb begin
        busy      = (r_state == S_FETCH) || (r_state == S_COMPUTE) || (r_state == S_OUTPUT);
        done      = (r_state == S_DONE);
        row_req   = (r_state == S_FETCH);
        res_valid = (r_state == S_OUTPUT);
        row_idx   = r_row_cnt;
        res_idx   = r_row_cnt;
        res_data  = r_res;
        dot_a     = r_row;
        dot_b     = r_vec;
    end

endmodule

// File: tb/tb_matvec_sequencer.sv
// Testbench for matvec_sequencer (WIDTH=8, LEN=8, ROWS=2) with a
// behavioural dot-product engine and a reference model of y = M*x.
module tb_matvec_sequencer;

    localparam int W    = 8;
    localparam int LEN  = 8;
    localparam int ROWS = 2;
    localparam int IW   = 1;

    typedef logic [LEN-1:0][W-1:0] vec_t;

    logic          clk       = 1'b0;
    logic          rst_n     = 1'b0;
    logic          start     = 1'b0;
    logic          abort     = 1'b0;
    logic          row_valid = 1'b0;
    logic          res_ready = 1'b0;
    vec_t          vec_in    = '0;
    vec_t          row_data  = '0;
    vec_t          dot_a;
    vec_t          dot_b;
    logic          busy;
    logic          done;
    logic          row_req;
    logic          res_valid;
    logic [IW-1:0] row_idx;
    logic [IW-1:0] res_idx;
    logic [W-1:0]  dot_result;
    logic [W-1:0]  res_data;

    int checks = 0;
    int errors = 0;

    matvec_sequencer #(.WIDTH(W), .LEN(LEN), .ROWS(ROWS)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .abort     (abort),
        .vec_in    (vec_in),
        .busy      (busy),
        .done      (done),
        .row_req   (row_req),
        .row_idx   (row_idx),
        .row_valid (row_valid),
        .row_data  (row_data),
        .dot_a     (dot_a),
        .dot_b     (dot_b),
        .dot_result(dot_result),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .res_idx   (res_idx)
    );

    always #5 clk = ~clk;

    // External combinational engine, truncating modulo 2^W
    always_comb begin
        int unsigned acc;
        acc = 0;
        for (int i = 0; i < LEN; i++) acc = acc + int'(dot_a[i]) * int'(dot_b[i]);
        dot_result = W'(acc);
    end

    function automatic logic [W-1:0] ref_dot(input vec_t x, input vec_t r);
        int unsigned s;
        s = 0;
        for (int i = 0; i < LEN; i++) s = s + int'(x[i]) * int'(r[i]);
        return W'(s % 256);
    endfunction

    function automatic vec_t fill(input int v);
        vec_t t;
        for (int i = 0; i < LEN; i++) t[i] = W'(v);
        return t;
    endfunction

    function automatic vec_t ramp();
        vec_t t;
        for (int i = 0; i < LEN; i++) t[i] = W'(i + 1);
        return t;
    endfunction

    function automatic vec_t rnd_vec();
        vec_t t;
        for (int i = 0; i < LEN; i++) t[i] = W'($urandom);
        return t;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_busy"}, 64'(busy), 64'(0));
        check({tag, "_done"}, 64'(done), 64'(0));
        check({tag, "_row_req"}, 64'(row_req), 64'(0));
        check({tag, "_res_valid"}, 64'(res_valid), 64'(0));
    endtask

    // One full job; vd*/rd* are the stall cycles before row_valid / res_ready
    // per row, noise adds stray start pulses, vec_in changes and
    // row_valid/res_ready toggling while they must be ignored.
    task automatic run_job(input vec_t x, input vec_t m0, input vec_t m1,
                           input int vd0, input int vd1, input int rd0, input int rd1,
                           input bit noise);
        vec_t m[ROWS];
        int   vd[ROWS];
        int   rd[ROWS];
        int   exp_len, cyc, row, vw, rw;
        bit   fin;
        m[0] = m0;  m[1] = m1;
        vd[0] = vd0; vd[1] = vd1;
        rd[0] = rd0; rd[1] = rd1;
        exp_len = 3 * ROWS + 1 + vd0 + vd1 + rd0 + rd1;

        vec_in = x;
        start  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        if (noise) vec_in = rnd_vec();
        cyc = 0; row = 0; vw = 0; rw = 0; fin = 1'b0;
        while (!fin && cyc < 300) begin
            cyc++;
            check("dot_b_latched", 64'(dot_b), 64'(x));
            if (done) begin
                check("done_cycle", 64'(cyc), 64'(exp_len));
                check("busy_in_done", 64'(busy), 64'(0));
                check("rows_done", 64'(row), 64'(ROWS));
                fin = 1'b1;
            end else begin
                check("busy", 64'(busy), 64'(1));
            end
            check("req_and_resv", 64'(row_req & res_valid), 64'(0));
            row_valid = 1'b0;
            res_ready = 1'b0;
            if (noise) row_data = rnd_vec();
            if (row_req && row < ROWS) begin
                check("row_idx", 64'(row_idx), 64'(row));
                if (vw == vd[row]) begin
                    row_valid = 1'b1;
                    row_data  = m[row];
                    vw = 0;
                end else begin
                    vw++;
                end
            end else if (noise) begin
                row_valid = 1'($urandom);
            end
            if (res_valid && row < ROWS) begin
                check("res_idx", 64'(res_idx), 64'(row));
                check("res_data", 64'(res_data), 64'(ref_dot(x, m[row])));
                check("dot_a", 64'(dot_a), 64'(m[row]));
                if (rw == rd[row]) begin
                    res_ready = 1'b1;
                    rw = 0;
                    row++;
                end else begin
                    rw++;
                end
            end else if (noise) begin
                res_ready = 1'($urandom);
            end
            if (noise) start = 1'($urandom);
            @(negedge clk);
        end
        if (!fin) check("done_timeout", 64'(0), 64'(1));
        start     = 1'b0;
        row_valid = 1'b0;
        res_ready = 1'b0;
        check_idle("after_job");
    endtask

    initial begin
        vec_t xa, xb;

        // Reset state
        repeat (2) @(negedge clk);
        check_idle("reset");
        check("reset_row_idx", 64'(row_idx), 64'(0));
        check("reset_res_idx", 64'(res_idx), 64'(0));
        check("reset_res_data", 64'(res_data), 64'(0));
        check("reset_dot_a", 64'(dot_a), 64'(0));
        check("reset_dot_b", 64'(dot_b), 64'(0));
        rst_n = 1'b1;
        @(negedge clk);

        // Basic job: results 36 then 16, done at cycle 7
        run_job(fill(1), ramp(), fill(2), 0, 0, 0, 0, 1'b0);
        // Result backpressure on row 0
        run_job(fill(1), ramp(), fill(2), 0, 0, 5, 0, 1'b0);
        // Fetch stall on row 1
        run_job(fill(1), ramp(), fill(2), 0, 4, 0, 0, 1'b0);
        // Overflow: 8*255*2 = 4080 -> 0xF0
        run_job(fill(255), fill(2), fill(2), 0, 0, 0, 0, 1'b0);
        check("overflow_last", 64'(res_data), 64'(8'hF0));

        // Abort in OUTPUT while result is held
        xa = fill(3);
        vec_in = xa; start = 1'b1;
        @(negedge clk);
        start = 1'b0; row_valid = 1'b1; row_data = ramp();
        @(negedge clk);
        row_valid = 1'b0;
        @(negedge clk);
        check("abort_pre_resv", 64'(res_valid), 64'(1));
        res_ready = 1'b0; abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check_idle("abort_output");
        repeat (3) begin
            @(negedge clk);
            check_idle("abort_quiet");
        end

        // Abort in FETCH beats a simultaneous row_valid
        vec_in = xa; start = 1'b1;
        @(negedge clk);
        start = 1'b0; row_valid = 1'b1; row_data = ramp(); abort = 1'b1;
        @(negedge clk);
        row_valid = 1'b0; abort = 1'b0;
        check_idle("abort_fetch");

        // Fresh job after aborts with a new x
        run_job(fill(4), ramp(), fill(5), 1, 0, 0, 2, 1'b0);

        // Start pulses and vec_in changes during the job are ignored
        run_job(fill(1), ramp(), fill(2), 1, 2, 2, 1, 1'b1);

        // Randomised jobs
        for (int k = 0; k < 6; k++) begin
            xb = rnd_vec();
            run_job(xb, rnd_vec(), rnd_vec(),
                    int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                    int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 1'b1);
        end

        // Async reset asserted while in COMPUTE
        vec_in = fill(7); start = 1'b1;
        @(negedge clk);
        start = 1'b0; row_valid = 1'b1; row_data = fill(9);
        @(negedge clk);
        row_valid = 1'b0;
        check("compute_busy", 64'(busy), 64'(1));
        #2 rst_n = 1'b0;
        #1;
        check_idle("midjob_reset");
        check("midjob_reset_row_idx", 64'(row_idx), 64'(0));
        check("midjob_reset_res_data", 64'(res_data), 64'(0));
        check("midjob_reset_dot_a", 64'(dot_a), 64'(0));
        check("midjob_reset_dot_b", 64'(dot_b), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_job(fill(2), ramp(), fill(1), 0, 0, 0, 0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
